// File: rtl/palette_ram_banked_pkg.sv
// ============================================================================
// Module      : palette_pkg
// Description : Shared types, constants and the fade scaler for the palette.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package palette_pkg;

  localparam int FADE_MAX = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } pal_state_e;

  // Brightness levels above FADE_MAX saturate, so 16 and up are identity.
  function automatic rgb12_t fade_scale(rgb12_t c, logic [4:0] level);
    logic [4:0] f;
    rgb12_t     o;
    f   = (level > 5'(FADE_MAX)) ? 5'(FADE_MAX) : level;
    o.r = 4'((9'(c.r) * 9'(f)) >> 4);
    o.g = 4'((9'(c.g) * 9'(f)) >> 4);
    o.b = 4'((9'(c.b) * 9'(f)) >> 4);
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/palette_ram_banked_if.sv
// ============================================================================
// Module      : palette_ram_banked_if
// Description : Read, write, fade and status signals of the banked palette.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface palette_ram_banked_if #(
  parameter int IDX_W  = 5,
  parameter int BANK_W = 2
);
  logic              rd_valid;
  logic [BANK_W-1:0] rd_bank;
  logic [IDX_W-1:0]  rd_index;
  logic              rd_ready;
  logic [4:0]        fade_level;
  logic              out_valid;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;
  logic              out_transparent;
  logic              wr_valid;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_index;
  logic [11:0]       wr_color;
  logic              wr_ready;
  logic              init_busy;

  modport master (
    output rd_valid, rd_bank, rd_index, fade_level,
    output wr_valid, wr_bank, wr_index, wr_color,
    input  rd_ready, wr_ready, init_busy,
    input  out_valid, red, green, blue, out_transparent
  );

  modport slave (
    input  rd_valid, rd_bank, rd_index, fade_level,
    input  wr_valid, wr_bank, wr_index, wr_color,
    output rd_ready, wr_ready, init_busy,
    output out_valid, red, green, blue, out_transparent
  );
endinterface

`default_nettype wire

// File: rtl/palette_ram_banked_fade.sv
// ============================================================================
// Module      : palette_fade
// Description : Combinational per-channel brightness scaler with level clamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_fade
  import palette_pkg::*;
(
  input  rgb12_t     color_i,
  input  logic [4:0] level_i,
  output rgb12_t     color_o
);

  assign color_o = fade_scale(color_i, level_i);

endmodule

`default_nettype wire

// File: rtl/palette_ram_banked.sv
// ============================================================================
// Module      : palette_ram_banked
// Description : Multi-bank 12-bit palette RAM, 2-stage read with fade/transp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_ram_banked
  import palette_pkg::*;
#(
  parameter int          IDX_W      = 5,
  parameter int          N_BANKS    = 4,
  parameter int          BANK_W     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  parameter bit          TRANSP_EN  = 1'b1,
  parameter int unsigned TRANSP_IDX = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  palette_ram_banked_if.slave   pal
);

  localparam int                ADDR_W    = BANK_W + IDX_W;
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BANKS * (2 ** IDX_W) - 1);

  pal_state_e        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;
  logic              ready_q;

  rgb12_t            mem_q [DEPTH];

  logic              w_rd_fire;
  logic              w_wr_fire;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_rd_in_range;
  logic              w_wr_in_range;
  logic              w_rd_transp;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  rgb12_t            w_mem_wdata;

  logic              s1_valid_q;
  rgb12_t            s1_word_q;
  logic              s1_transp_q;

  rgb12_t            w_faded;
  rgb12_t            out_rgb_d;
  logic              out_transp_d;
  logic              out_valid_q;
  rgb12_t            out_rgb_q;
  logic              out_transp_q;

  assign w_rd_fire = pal.rd_valid & ready_q;
  assign w_wr_fire = pal.wr_valid & ready_q;
  assign w_rd_addr = {pal.rd_bank, pal.rd_index};
  assign w_wr_addr = {pal.wr_bank, pal.wr_index};

  // Bank codes past N_BANKS only exist when N_BANKS is not a power of two.
  generate
    if (N_BANKS == (2 ** BANK_W)) begin : g_full_banks
      assign w_rd_in_range = 1'b1;
      assign w_wr_in_range = 1'b1;
    end else begin : g_partial_banks
      localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANKS - 1);
      assign w_rd_in_range = (pal.rd_bank <= LAST_BANK);
      assign w_wr_in_range = (pal.wr_bank <= LAST_BANK);
    end
  endgenerate

  generate
    if (TRANSP_EN) begin : g_transp
      localparam logic [IDX_W-1:0] TRANSP_IDX_L = IDX_W'(TRANSP_IDX);
      assign w_rd_transp = (pal.rd_index == TRANSP_IDX_L);
    end else begin : g_no_transp
      assign w_rd_transp = 1'b0;
    end
  endgenerate

  // Control FSM: clear sweep after reset, then normal operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= INIT;
          clr_cnt_q <= '0;
          busy_q    <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = w_wr_addr;
    w_mem_wdata = pal.wr_color;
    if (!rst_i) begin
      if (state_q == INIT) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = clr_cnt_q;
        w_mem_wdata = '0;
      end else if (w_wr_fire && w_wr_in_range) begin
        w_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      mem_q[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Stage 1 samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s1_transp_q <= 1'b0;
    end else begin
      s1_valid_q <= w_rd_fire;
      if (w_rd_fire) begin
        s1_word_q   <= w_rd_in_range ? mem_q[w_rd_addr] : '0;
        s1_transp_q <= w_rd_transp;
      end
    end
  end

  palette_fade u_fade (
    .color_i (s1_word_q),
    .level_i (pal.fade_level),
    .color_o (w_faded)
  );

  always_comb begin
    out_rgb_d    = out_rgb_q;
    out_transp_d = out_transp_q;
    if (s1_valid_q) begin
      if (s1_transp_q) begin
        out_rgb_d    = '0;
        out_transp_d = 1'b1;
      end else begin
        out_rgb_d    = w_faded;
        out_transp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_rgb_q    <= '0;
      out_transp_q <= 1'b0;
    end else begin
      out_valid_q  <= s1_valid_q;
      out_rgb_q    <= out_rgb_d;
      out_transp_q <= out_transp_d;
    end
  end

  assign pal.rd_ready        = ready_q;
  assign pal.wr_ready        = ready_q;
  assign pal.init_busy       = busy_q;
  assign pal.out_valid       = out_valid_q;
  assign pal.red             = out_rgb_q.r;
  assign pal.green           = out_rgb_q.g;
  assign pal.blue            = out_rgb_q.b;
  assign pal.out_transparent = out_transp_q;

endmodule

`default_nettype wire

// File: doc/palette_ram_banked.md
Name: palette_ram_banked

Overview:
- Writable, multi-bank colour palette for sprite and tile drawing, replacing fixed per-sprite palette ROMs.
- Maps a (bank, index) pair from the drawing pipeline to 12-bit RGB through a 2-stage registered read pipeline.
- Provides a runtime write port, a global fade (brightness) stage and an optional transparent-index flag.
- Sits between sprite/tile index fetch and the VGA colour mux.

Parameters:
- IDX_W, 5, palette index width; entries per bank = 2**IDX_W.
- N_BANKS, 4, number of independent palettes.
- BANK_W, $clog2(N_BANKS) (min 1), bank select width.
- TRANSP_EN, 1, enables transparent-index detection.
- TRANSP_IDX, 0, index flagged transparent when TRANSP_EN=1.

Ports:
- Clk  in  1  system clock (all logic on rising edge).
- Reset  in  1  synchronous, active-high reset.
- rd_valid  in  1  read request this cycle.
- rd_bank  in  BANK_W  palette bank for the read.
- rd_index  in  IDX_W  colour index for the read.
- rd_ready  out  1  read accepted when rd_valid & rd_ready.
- fade_level  in  5  brightness 0..16; values >16 are treated as 16.
- out_valid  out  1  red/green/blue/out_transparent are valid.
- red, green, blue  out  4 each  faded colour channels.
- out_transparent  out  1  pixel index equals TRANSP_IDX.
- wr_valid  in  1  write request.
- wr_bank  in  BANK_W  target bank.
- wr_index  in  IDX_W  target entry.
- wr_color  in  12  {R,G,B}, 4 bits each.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Storage: N_BANKS*2**IDX_W words of 12 bits. Address = {bank, index}.
- FSM states INIT and RUN. Reset high (any cycle, including mid-operation) forces INIT, clear counter 0, and flushes both pipeline stages.
- INIT:
  - Writes 12'h000 to address = counter, one per cycle; counter increments.
  - On the last address (N_BANKS*2**IDX_W-1), the next state is RUN.
  - init_busy=1, rd_ready=0, wr_ready=0.
  - Default config: 128 cycles of INIT after Reset deasserts.
- RUN: init_busy=0, rd_ready=1, wr_ready=1. No backpressure exists on the output side.
- Reset values: out_valid=0, red=green=blue=0, out_transparent=0, rd_ready=0, wr_ready=0, init_busy=1.
- Write: an accepted write updates the entry at the clock edge ending the accept cycle.
- Read pipeline, latency 2:
  - Cycle N: accept read.
  - Cycle N+1: stage-1 register holds the RAM word, the valid bit and the transparent flag.
  - Cycle N+2: out_valid=1 with outputs registered.
  - Full throughput: one read per cycle.
- Same-address read and write in the same cycle: the read returns the OLD value (read-first). A read in cycle N+1 or later sees the new value.
- Fade arithmetic:
  - f = min(fade_level,16), sampled in stage 2, i.e. the cycle before out_valid.
  - Per channel: out = (c*f)>>4, using a 9-bit product truncated to 4 bits.
  - f=16 gives identity; f=0 gives black.
- Transparency: when TRANSP_EN=1 and rd_index==TRANSP_IDX, out_transparent=1 and red=green=blue=0, regardless of the stored value or fade. When TRANSP_EN=0, out_transparent is always 0.
- Idle cycles: out_valid=0, and colour outputs hold their last value. Consumers qualify with out_valid.
- Out-of-range bank (N_BANKS not a power of 2): reads return 12'h000 with out_valid=1. Writes are dropped, with wr_ready still 1.

Decomposition:
- Package palette_pkg holds:
  - typedef rgb12_t as a packed struct of 4-bit r, g, b;
  - constant FADE_MAX=16;
  - enum pal_state_e {INIT, RUN};
  - function fade_scale(rgb12_t, logic [4:0]).
- One sub-module, palette_fade: the combinational per-channel scaler with clamp, reused by the HUD colour path.
- RAM inferred in the top module as a simple dual-port array. No vendor IP.

Test Plan:
- Reset, then hold Reset 3 cycles and release -> init_busy=1 for exactly 128 cycles, then 0. rd_ready/wr_ready rise the same cycle. Reading bank 2, index 7 with fade 16 gives rgb 000, out_valid exactly 2 cycles after accept.
- Write bank1/idx5=12'hF84, then read it every cycle for 4 cycles with fade 16 -> each out_valid cycle gives red=F, green=8, blue=4. Back-to-back reads give 4 consecutive out_valid.
- Same cycle: write bank0/idx3=12'hABC and read bank0/idx3, old value 12'h123 -> first result 123; a read issued the next cycle gives ABC.
- Fade on entry 12'hF84: fade 8 -> 7,4,2; fade 0 -> 0,0,0; fade 31 -> F,8,4 (clamped).
- Write idx0=12'hFFF, read idx0 with TRANSP_EN=1 -> out_transparent=1 and rgb 000. The same test with TRANSP_EN=0 -> out_transparent=0 and rgb FFF.
- Assert Reset for 1 cycle while 2 reads are in flight -> out_valid=0 on the following cycles, the earlier write to bank1/idx5 reads back 000 after INIT, and init_busy re-asserts for 128 cycles.
